// File: rtl/nv_ram_rwsp_80x16_pipe.sv
// nv_ram_rwsp_80x16_pipe: 80x16 register-file RAM, one write port, one read port, two-stage registered read.
module nv_ram_rwsp_80x16_pipe #(
  parameter logic FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 1'b0,
  parameter int   DEPTH = 80,
  parameter int   WIDTH = 16
) (
  input  logic             nvdla_core_clk_mgated,
  input  logic             nvdla_core_rstn,
  input  logic [31:0]      pwrbus_ram_pd,
  input  logic [6:0]       wa,
  input  logic             we,
  input  logic [WIDTH-1:0] di,
  input  logic [6:0]       ra,
  input  logic             re,
  input  logic             ore,
  output logic [WIDTH-1:0] dout
);
  localparam logic [6:0] DEPTH_A = 7'(DEPTH);
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [WIDTH-1:0] rd_q;
  logic             unused_pd;
  assign unused_pd = ^pwrbus_ram_pd;
  // Array is deliberately left unreset; stage 1 reads it before the write lands.
  always_ff @(posedge nvdla_core_clk_mgated)
    if (we && wa < DEPTH_A) mem[wa] <= di;
  always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      rd_q <= '0;
      dout <= '0;
    end else begin
      if (re) rd_q <= (ra < DEPTH_A) ? mem[ra] : '0;
      if (ore) dout <= rd_q;
    end
  always_ff @(posedge nvdla_core_clk_mgated)
    if (!FORCE_CONTENTION_ASSERTION_RESET_ACTIVE && nvdla_core_rstn)
      assert (!(we && re && wa == ra && wa < DEPTH_A))
        else $error("nv_ram_rwsp_80x16_pipe: write/read contention at address %0d", wa);
endmodule

// File: tb/tb_nv_ram_rwsp_80x16_pipe.sv
// tb_nv_ram_rwsp_80x16_pipe: directed self-checking bench for the 80x16 pipelined register-file RAM.
module tb_nv_ram_rwsp_80x16_pipe;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] pd;
  logic [6:0]  wa, ra;
  logic        we, re, ore;
  logic [15:0] di, dout;
  logic [15:0] model [0:79];
  logic [15:0] hold_v;
  int total = 0;
  int bad = 0;

  nv_ram_rwsp_80x16_pipe #(.FORCE_CONTENTION_ASSERTION_RESET_ACTIVE(1'b1)) dut (
    .nvdla_core_clk_mgated(clk),
    .nvdla_core_rstn(rstn),
    .pwrbus_ram_pd(pd),
    .wa(wa),
    .we(we),
    .di(di),
    .ra(ra),
    .re(re),
    .ore(ore),
    .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] exp);
    total++;
    assert (dout === exp) else begin
      bad++;
      $error("FAIL %s dout=%h expected=%h", tag, dout, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [15:0] d);
    we = 1'b1; wa = a; di = d;
    tick();
    we = 1'b0;
    if (a < 7'd80) model[a] = d;
  endtask

  task automatic rd2(input logic [6:0] a);
    re = 1'b1; ra = a; ore = 1'b0;
    tick();
    re = 1'b0; ore = 1'b1;
    tick();
    ore = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; pd = 32'h0; wa = '0; ra = '0; we = 1'b0; re = 1'b0; ore = 1'b0; di = '0;
    tick(); tick();
    check("reset_dout", 16'h0);
    rstn = 1'b1;
    tick();
    check("post_release", 16'h0);

    wr(7'd5, 16'hA5A5);
    rd2(7'd5);
    check("wr_rd_5", 16'hA5A5);

    // Asynchronous reset with dirty rd_q/dout, no clock edge needed.
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("async_reset", 16'h0);
    tick();
    rstn = 1'b1;
    tick();
    check("reset_hold", 16'h0);
    ore = 1'b1;
    tick();
    ore = 1'b0;
    check("rdq_cleared", 16'h0);
    pd = 32'hFFFF_FFFF;
    rd2(7'd5);
    check("retained_5", 16'hA5A5);

    for (int i = 0; i < 80; i++) wr(7'(i), 16'(i * 3));
    for (int i = 0; i <= 80; i++) begin
      re = (i < 80); ra = 7'(i % 80); ore = (i >= 1);
      tick();
      if (i >= 1) check("stream", 16'((i - 1) * 3));
    end
    re = 1'b0; ore = 1'b0;

    hold_v = dout;
    re = 1'b1; ra = 7'd7;
    tick();
    re = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ra = 7'(20 + i);
      tick();
      check("hold", hold_v);
    end
    ore = 1'b1;
    tick();
    ore = 1'b0;
    check("hold_load", 16'd21);

    wr(7'd10, 16'h1111);
    we = 1'b1; wa = 7'd10; di = 16'h2222; re = 1'b1; ra = 7'd10;
    tick();
    we = 1'b0; re = 1'b0; ore = 1'b1;
    model[10] = 16'h2222;
    tick();
    ore = 1'b0;
    check("contention_old", 16'h1111);
    rd2(7'd10);
    check("contention_new", 16'h2222);

    wr(7'd80, 16'hFFFF);
    for (int i = 0; i <= 80; i++) begin
      re = (i < 80); ra = 7'(i % 80); ore = (i >= 1);
      tick();
      if (i >= 1) check("oor_write", model[i - 1]);
    end
    re = 1'b0; ore = 1'b0;
    rd2(7'd127);
    check("oor_read", 16'h0);
    rd2(7'd79);
    check("last_entry", 16'd237);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
